e_mdu: RTL

//   Execute-stage multiply/divide unit of the P7 pipeline. Consumes the E-stage operands
//   (E_gpr_rs/E_gpr_rt) and a decoded MDU opcode, and owns the architectural HI/LO registers.

---
 rtl/e_mdu.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit. Owns the architectural HI/LO
// registers, computes the 64-bit result of mult/multu/div/divu when the
// operation is accepted, and holds busy high for MULT_CYCLES or DIV_CYCLES
// cycles before committing that result to HI/LO.
//
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous, active-high; aborts any in-flight operation
//   Req      - exception/interrupt this cycle; no new op is accepted
//   mdu_op   - 0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 mfhi,8 mflo
//   rs, rt   - forwarded E-stage operands
//   start    - comb: a mult/multu/div/divu is accepted this cycle
//   busy     - registered: an operation is in flight
//   hi, lo   - registered HI/LO
//   rd_data  - comb: hi for mfhi, lo for mflo, else 0
//
// Handshake: an op is accepted only when !Req && !busy. start is the accept
// strobe for the multi-cycle ops; mthi/mtlo take effect on the same edge.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    logic [CW-1:0] count_q, count_d;
    logic          busy_q, busy_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    // Set when the pending op is a divide by zero: completion leaves HI/LO alone.
    logic          pend_skip_q, pend_skip_d;

    // All arithmetic is done on 64-bit extended operands; the signed divide of
    // 0x80000000 by -1 therefore yields +2^31, whose low word is 0x80000000.
    logic signed [63:0] sa, sb, sb_nz;
    logic        [63:0] ua, ub, ub_nz;
    logic        [63:0] prod_s, prod_u;
    logic        [31:0] quot_s, rem_s, quot_u, rem_u;
    logic               is_mult, is_div, rt_zero;
    logic        [63:0] result;

    always_comb begin
        sa      = {{32{rs[31]}}, rs};
        sb      = {{32{rt[31]}}, rt};
        ua      = {32'd0, rs};
        ub      = {32'd0, rt};
        rt_zero = (rt == 32'd0);
        // Substitute a divisor of 1 on divide-by-zero so the divider never
        // produces X; the result is discarded at completion anyway.
        sb_nz   = rt_zero ? 64'sd1 : sb;
        ub_nz   = rt_zero ? 64'd1  : ub;
        prod_s  = sa * sb;
        prod_u  = ua * ub;
        quot_s  = 32'(sa / sb_nz);
        rem_s   = 32'(sa % sb_nz);
        quot_u  = 32'(ua / ub_nz);
        rem_u   = 32'(ua % ub_nz);

        is_mult = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
        is_div  = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);

        case (mdu_op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   result = {rem_s, quot_s};
            OP_DIVU:  result = {rem_u, quot_u};
            default:  result = 64'd0;
        endcase
    end

    assign start = (is_mult || is_div) && !Req && !busy_q;

    always_comb begin
        count_d     = count_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        pend_hi_d   = pend_hi_q;
        pend_lo_d   = pend_lo_q;
        pend_skip_d = pend_skip_q;

        if (start) begin
            pend_hi_d   = result[63:32];
            pend_lo_d   = result[31:0];
            pend_skip_d = is_div && rt_zero;
            count_d     = is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end else if (count_q != '0) begin
            // In-flight ops complete even under Req: they belong to an
            // older, already committed instruction.
            count_d = count_q - CW'(1);
            if (count_q == CW'(1) && !pend_skip_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (!Req) begin
            if (mdu_op == OP_MTHI) hi_d = rs;
            if (mdu_op == OP_MTLO) lo_d = rs;
        end

        busy_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            busy_q      <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            pend_hi_q   <= 32'd0;
            pend_lo_q   <= 32'd0;
            pend_skip_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            busy_q      <= busy_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            pend_hi_q   <= pend_hi_d;
            pend_lo_q   <= pend_lo_d;
            pend_skip_q <= pend_skip_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        case (mdu_op)
            OP_MFHI: rd_data = hi_q;
            OP_MFLO: rd_data = lo_q;
            default: rd_data = 32'd0;
        endcase
    end
endmodule
